// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU host front end: op codes,
// sequencer state encoding and the order of operand words on inbus.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_LOAD,
    SEQ_RUN,
    SEQ_RESP
  } seq_state_t;

  // Operand words are loaded in this order after the load delay.
  localparam int WORD_A     = 0;
  localparam int WORD_Q     = 1;
  localparam int WORD_M     = 2;
  localparam int LOAD_WORDS = 3;

endpackage

// File: rtl/alu_op_watchdog.sv
// Cycle watchdog for serial execution units: counts enabled cycles after
// a clear and flags the cycle in which the TIMEOUT-th enabled cycle occurs.
module alu_op_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The count holds the number of enabled cycles already completed, so the
  // TIMEOUT-th enabled cycle is the one that sees count == TIMEOUT-1.
  assign expired = enable && (count == LAST);

  // Clear dominates; the counter saturates once it has expired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/alu_host_sequencer.sv
// Host-side front end for the serial 8-bit ALU: accepts one request,
// drives BEGIN/op_code/inbus, gathers the two result bytes from outbus and
// returns them as a 16-bit response, aborting via watchdog if END never comes.
module alu_host_sequencer
  import alu_pkg::*;
#(
  parameter int LOAD_DELAY = 1,
  parameter int RES_LAG    = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_opa,
  input  logic [7:0]  req_opb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        alu_begin,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_inbus,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_end
);

  localparam int LCW = $clog2(LOAD_DELAY + LOAD_WORDS) + 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_DELAY + LOAD_WORDS - 1);
  localparam logic [LCW-1:0] SLOT_A    = LCW'(LOAD_DELAY + WORD_A);
  localparam logic [LCW-1:0] SLOT_Q    = LCW'(LOAD_DELAY + WORD_Q);
  localparam logic [LCW-1:0] SLOT_M    = LCW'(LOAD_DELAY + WORD_M);
  localparam int HIST = RES_LAG + 1;

  seq_state_t     state, state_next;
  logic [1:0]     op_q;
  logic [15:0]    opa_q;
  logic [7:0]     opb_q;
  logic [LCW-1:0] load_cnt;
  logic [7:0]     hist [HIST];
  logic [7:0]     win  [HIST+1];
  logic           wd_clear, wd_enable, wd_expired;

  alu_op_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Only RUN cycles are counted; every other state keeps the watchdog cleared.
  assign wd_enable = (state == SEQ_RUN);
  assign wd_clear  = !wd_enable;

  // Result window: index 0 is this cycle's outbus, index i is i cycles ago.
  always_comb begin
    win[0] = alu_outbus;
    for (int i = 0; i < HIST; i++) begin
      win[i+1] = hist[i];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the per-state ALU/handshake outputs.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_begin   = 1'b0;
    alu_op_code = OP_ADD;
    alu_inbus   = 8'h00;
    case (state)
      SEQ_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = SEQ_START;
      end
      SEQ_START: begin
        alu_begin   = 1'b1;
        alu_op_code = op_q;
        state_next  = SEQ_LOAD;
      end
      SEQ_LOAD: begin
        alu_op_code = op_q;
        if (load_cnt == SLOT_A)      alu_inbus = opa_q[15:8];
        else if (load_cnt == SLOT_Q) alu_inbus = opa_q[7:0];
        else if (load_cnt == SLOT_M) alu_inbus = opb_q;
        if (load_cnt == LOAD_LAST) state_next = SEQ_RUN;
      end
      SEQ_RUN: begin
        alu_op_code = op_q;
        if (alu_end || wd_expired) state_next = SEQ_RESP;
      end
      SEQ_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Capture the request operands on acceptance; they stay put until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= 2'b00;
      opa_q <= 16'h0000;
      opb_q <= 8'h00;
    end else if (state == SEQ_IDLE && req_valid) begin
      op_q  <= req_op;
      opa_q <= req_opa;
      opb_q <= req_opb;
    end
  end

  // Load slot counter: restarts at the BEGIN cycle, advances through LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt <= '0;
    end else if (state == SEQ_START) begin
      load_cnt <= '0;
    end else if (state == SEQ_LOAD) begin
      load_cnt <= load_cnt + LCW'(1);
    end
  end

  // Outbus history, wiped at BEGIN so an early END never sees stale bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HIST; i++) hist[i] <= 8'h00;
    end else if (state == SEQ_START) begin
      for (int i = 0; i < HIST; i++) hist[i] <= 8'h00;
    end else if (state == SEQ_RUN) begin
      hist[0] <= alu_outbus;
      for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
    end
  end

  // Response latch: END takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_data    <= 16'h0000;
      rsp_timeout <= 1'b0;
    end else if (state == SEQ_RUN) begin
      if (alu_end) begin
        rsp_data    <= {win[RES_LAG+1], win[RES_LAG]};
        rsp_timeout <= 1'b0;
      end else if (wd_expired) begin
        rsp_data    <= 16'h0000;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
